// File: rtl/data_memory_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared types and helpers for the byte-addressable data memory
//           controller: access-size codes, FSM state encoding and the
//           alignment check used by the fault logic.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access-size codes carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // Number of byte lanes in one memory word
    localparam int LANES = 4;

    // Controller state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Captured request fields held while the access is in flight
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
    } req_ctl_t;

    // Half accesses need an even address, word accesses a multiple of four.
    // Byte accesses never misalign; the illegal size code is flagged
    // separately by the caller.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_ctrl_if
// Brief   : Valid/ready request port and response port of the data memory
//           controller, with master (datapath) and slave (memory) views.
// Revision: 1.0 - initial release
// ============================================================================
interface data_memory_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DBG_W  = 16
) ();

    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_uns;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [DBG_W-1:0]  dbg_rdata;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_rdata
    );

endinterface
`default_nettype wire

// File: rtl/data_memory_ctrl_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_align
// Brief   : Combinational lane steering for the data memory. Produces the
//           store byte-enables and replicated store word, and extracts and
//           sign/zero-extends the addressed lanes of a read word.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store path: replicate the right-justified data across every lane so
    // the byte-enables alone decide which lanes are written.
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        case (size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << lane;
                wword   = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                byte_en = 4'b1111;
                wword   = wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wword   = wdata;
            end
        endcase
    end

    // Load path: pick the addressed lanes, right-justify, then extend.
    // Word loads pass straight through and ignore the unsigned flag.
    always_comb begin
        case (lane)
            2'd0:    lane_byte = rword[7:0];
            2'd1:    lane_byte = rword[15:8];
            2'd2:    lane_byte = rword[23:16];
            default: lane_byte = rword[31:24];
        endcase
        lane_half = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_BYTE: rdata = {{24{~uns & lane_byte[7]}}, lane_byte};
            SIZE_HALF: rdata = {{16{~uns & lane_half[15]}}, lane_half};
            SIZE_WORD: rdata = rword;
            default:   rdata = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_ctrl
// Brief   : Byte-addressable data memory with a valid/ready request port,
//           byte/half/word loads and stores, programmable wait states and
//           detection of misaligned, illegal-size and out-of-range accesses.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int DBG_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_ctrl_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH);
    // Counter preload so that BUSY lasts exactly WAIT_CYCLES cycles
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        wait_cnt;

    // Request fields captured at accept
    req_ctl_t          cap_ctl;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    // Registered response
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [DBG_W-1:0]  dbg_rdata_q;

    // Request fields seen by the memory on the access edge
    req_ctl_t          sel_ctl;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              accept;
    logic              access;
    logic              out_of_range;
    logic              fault;
    logic              wr_en;
    logic [IDX_W-1:0]  word_idx;
    logic [3:0]        byte_en;
    logic [31:0]       wword;
    logic [31:0]       rword;
    logic [31:0]       load_data;
    logic [DATA_W-1:0] rsp_next;

    assign bus.req_ready = (state == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // The memory is touched on the edge that enters RESP: straight from IDLE
    // when there are no wait states, otherwise on the last BUSY cycle.
    assign access = !rst &&
                    (((WAIT_CYCLES == 0) && accept) ||
                     ((state == S_BUSY) && (wait_cnt == 4'd0)));

    // With no wait states the access coincides with accept, so the live bus
    // fields are used; otherwise the captured copy is.
    always_comb begin
        if (state == S_IDLE) begin
            sel_ctl.we   = bus.req_we;
            sel_ctl.size = bus.req_size;
            sel_ctl.uns  = bus.req_uns;
            sel_addr     = bus.req_addr;
            sel_wdata    = bus.req_wdata;
        end else begin
            sel_ctl      = cap_ctl;
            sel_addr     = cap_addr;
            sel_wdata    = cap_wdata;
        end
    end

    // Any address bit above the array span means the access is out of range
    if (ADDR_W > IDX_W + 2) begin : g_range
        assign out_of_range = |sel_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
        assign out_of_range = 1'b0;
    end

    assign word_idx = sel_addr[IDX_W+1:2];
    assign fault    = is_misaligned(sel_ctl.size, sel_addr[1:0]) ||
                      (sel_ctl.size == SIZE_ILL) || out_of_range;
    assign wr_en    = access && sel_ctl.we && !fault;
    assign rsp_next = (fault || sel_ctl.we) ? '0 : load_data;

    dmem_align u_align (
        .size    (sel_ctl.size),
        .uns     (sel_ctl.uns),
        .lane    (sel_addr[1:0]),
        .wdata   (sel_wdata),
        .rword   (rword),
        .byte_en (byte_en),
        .wword   (wword),
        .rdata   (load_data)
    );

    // One byte-wide array per lane; contents survive rst
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] mem [DEPTH] = '{default: 8'h00};

        // Lane write on the access edge when its byte-enable is set
        always @(posedge clk) begin
            if (wr_en && byte_en[g]) begin
                mem[word_idx] <= wword[8*g +: 8];
            end
        end

        assign rword[8*g +: 8] = mem[word_idx];
    end

    // Control FSM, wait counter, request capture and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            cap_ctl     <= '0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_ctl.we   <= bus.req_we;
                        cap_ctl.size <= bus.req_size;
                        cap_ctl.uns  <= bus.req_uns;
                        cap_addr     <= bus.req_addr;
                        cap_wdata    <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_BUSY;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Response fields change only here and hold otherwise
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= fault;
                rsp_rdata_q <= rsp_next;
                dbg_rdata_q <= rsp_next[DBG_W-1:0];
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_ctrl
// Brief   : Self-checking bench for data_memory_ctrl. Two instances, one with
//           no wait states and one with three, are driven by directed and
//           random accesses and compared with a byte-array memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst3 = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference byte memories, one per instance
    logic [7:0] mem0 [MEM_BYTES];
    logic [7:0] mem3 [MEM_BYTES];

    data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(32), .DBG_W(16)) bus0 ();
    data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(32), .DBG_W(16)) bus3 ();

    data_memory_ctrl #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0), .DBG_W(16)
    ) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    data_memory_ctrl #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3), .DBG_W(16)
    ) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_store(input int which, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
        int unsigned nb;
        int unsigned ua;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ua = a;
        for (int unsigned i = 0; i < nb; i++) begin
            if (which == 0) mem0[ua + i] = 8'(d >> (8 * i));
            else            mem3[ua + i] = 8'(d >> (8 * i));
        end
    endtask

    task automatic model_op(input int which, input logic we, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic e);
        int unsigned nb;
        int unsigned ua;
        longint unsigned val;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        ua = a;
        rd = 32'h0;
        e  = 1'b0;
        if (nb == 0 || (ua % nb) != 0 || ua >= MEM_BYTES) begin
            e = 1'b1;
        end else if (we) begin
            model_store(which, sz, a, d);
        end else begin
            val = 0;
            for (int unsigned i = 0; i < nb; i++) begin
                if (which == 0) val = val | (longint'(mem0[ua + i]) << (8 * i));
                else            val = val | (longint'(mem3[ua + i]) << (8 * i));
            end
            if (!u && nb < 4 && ((val >> (8 * nb - 1)) & 64'd1) == 64'd1)
                val = val | ~((64'd1 << (8 * nb)) - 64'd1);
            rd = val[31:0];
        end
    endtask

    // ---------------- bus access ----------------
    task automatic drive(input int which, input logic v, input logic we,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus0.req_valid = v;  bus0.req_we = we; bus0.req_size = sz;
            bus0.req_uns = u;    bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus3.req_valid = v;  bus3.req_we = we; bus3.req_size = sz;
            bus3.req_uns = u;    bus3.req_addr = a; bus3.req_wdata = d;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic rv,
                          output logic [31:0] rd, output logic er, output logic [15:0] dbg);
        if (which == 0) begin
            rdy = bus0.req_ready; rv = bus0.rsp_valid; rd = bus0.rsp_rdata;
            er = bus0.rsp_err;    dbg = bus0.dbg_rdata;
        end else begin
            rdy = bus3.req_ready; rv = bus3.rsp_valid; rd = bus3.rsp_rdata;
            er = bus3.rsp_err;    dbg = bus3.dbg_rdata;
        end
    endtask

    // One complete access; entered and left on a falling edge. lat counts
    // falling edges from the accept edge to the response.
    task automatic xact(input int which, input logic we, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic [15:0] dbg,
                        output int lat, output bit to);
        logic rdy;
        logic rv;
        int   n;
        to  = 1'b0;
        lat = 0;
        drive(which, 1'b1, we, sz, u, a, d);
        sample(which, rdy, rv, rd, er, dbg);
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            sample(which, rdy, rv, rd, er, dbg);
        end
        if (!rdy) begin
            to = 1'b1;
            drive(which, 1'b0, we, sz, u, a, d);
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the fields so any use of post-accept inputs shows up
        drive(which, 1'b0, ~we, ~sz, ~u, ~a, ~d);
        do begin
            @(negedge clk);
            lat++;
            sample(which, rdy, rv, rd, er, dbg);
        end while (!rv && lat < 40);
        if (!rv) to = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic rdy, rv, er;
        logic [31:0] rd;
        logic [15:0] dbg;
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w * 3, rdy, rv, rd, er, dbg);
            n_checks++;
            if (rdy !== 1'b0) begin n_errors++; $display("FAIL reset_ready dut%0d: got %b want 0", w * 3, rdy); end
            n_checks++;
            if ({rv, er} !== 2'b00) begin n_errors++; $display("FAIL reset_valid_err dut%0d: got %b want 00", w * 3, {rv, er}); end
            n_checks++;
            if (rd !== 32'h0 || dbg !== 16'h0) begin n_errors++; $display("FAIL reset_data dut%0d: got %h/%h want 0/0", w * 3, rd, dbg); end
        end
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w * 3, rdy, rv, rd, er, dbg);
            n_checks++;
            if (rdy !== 1'b1) begin n_errors++; $display("FAIL ready_after_reset dut%0d: got %b want 1", w * 3, rdy); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; logic [15:0] dbg; int lat; bit to;
        xact(0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, dbg, lat, to);
        model_store(0, SIZE_WORD, 32'h10, 32'hDEADBEEF);
        n_checks++;
        if (to || lat != 1 || er !== 1'b0 || rd !== 32'h0) begin
            n_errors++; $display("FAIL sw_word: got to=%0d lat=%0d err=%b rd=%h want 0/1/0/0", to, lat, er, rd);
        end
        xact(0, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || lat != 1) begin n_errors++; $display("FAIL lw_latency: got to=%0d lat=%0d want lat 1", to, lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_errors++; $display("FAIL lw_word: got %h err=%b want deadbeef err=0", rd, er); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic er; logic [15:0] dbg; int lat; bit to;
        xact(0, 1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'hFFFFFFDE || er !== 1'b0) begin n_errors++; $display("FAIL lb_sign: got %h want ffffffde", rd); end
        xact(0, 1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'h000000DE || er !== 1'b0) begin n_errors++; $display("FAIL lbu_zero: got %h want 000000de", rd); end
        xact(0, 1'b0, SIZE_HALF, 1'b0, 32'h10, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'hFFFFBEEF || er !== 1'b0) begin n_errors++; $display("FAIL lh_sign: got %h want ffffbeef", rd); end
        xact(0, 1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h00000055, rd, er, dbg, lat, to);
        model_store(0, SIZE_BYTE, 32'h11, 32'h00000055);
        xact(0, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'hDEAD55EF) begin n_errors++; $display("FAIL sb_merge: got %h want dead55ef", rd); end
        n_checks++;
        if (dbg !== 16'h55EF) begin n_errors++; $display("FAIL dbg_tap: got %h want 55ef", dbg); end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic er; logic [15:0] dbg; int lat; bit to;
        xact(0, 1'b0, SIZE_WORD, 1'b0, 32'h12, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL lw_misaligned: got lat=%0d err=%b rd=%h want 1/1/0", lat, er, rd); end
        xact(0, 1'b1, SIZE_WORD, 1'b0, 32'h12, 32'h11223344, rd, er, dbg, lat, to);
        n_checks++;
        if (to || er !== 1'b1) begin n_errors++; $display("FAIL sw_misaligned: got err=%b want 1", er); end
        xact(0, 1'b1, SIZE_HALF, 1'b0, 32'h401, 32'h0000AAAA, rd, er, dbg, lat, to);
        n_checks++;
        if (to || er !== 1'b1) begin n_errors++; $display("FAIL sh_0x401: got err=%b want 1", er); end
        xact(0, 1'b1, SIZE_HALF, 1'b0, 32'h410, 32'h0000AAAA, rd, er, dbg, lat, to);
        n_checks++;
        if (to || er !== 1'b1) begin n_errors++; $display("FAIL sh_out_of_range: got err=%b want 1", er); end
        xact(0, 1'b1, SIZE_ILL, 1'b0, 32'h10, 32'h99999999, rd, er, dbg, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL size11_store: got err=%b rd=%h want 1/0", er, rd); end
        xact(0, 1'b0, SIZE_ILL, 1'b0, 32'h10, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL size11_load: got err=%b rd=%h want 1/0", er, rd); end
        xact(0, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || er !== 1'b0 || rd !== 32'hDEAD55EF) begin n_errors++; $display("FAIL word10_unchanged: got %h want dead55ef", rd); end
    endtask

    task automatic test_hold();
        logic rdy, rv, er; logic [31:0] rd; logic [15:0] dbg; int lat; bit to;
        bit bad;
        xact(0, 1'b0, SIZE_HALF, 1'b1, 32'h12, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'h0000DEAD) begin n_errors++; $display("FAIL lhu_upper: got %h want 0000dead", rd); end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sample(0, rdy, rv, rd, er, dbg);
            if (rv !== 1'b0 || rd !== 32'h0000DEAD || er !== 1'b0 || dbg !== 16'hDEAD) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin n_errors++; $display("FAIL response_hold: got valid=%b rd=%h want 0 and 0000dead", rv, rd); end
    endtask

    task automatic test_wait();
        logic rdy, rv, er; logic [31:0] rd; logic [15:0] dbg;
        int n;
        n = 0;
        sample(3, rdy, rv, rd, er, dbg);
        while (!rdy && n < 20) begin @(negedge clk); n++; sample(3, rdy, rv, rd, er, dbg); end
        drive(3, 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'hA5A51234);
        model_store(3, SIZE_WORD, 32'h40, 32'hA5A51234);
        @(posedge clk);
        #1;
        // Second request presented while busy; must be held, not accepted
        drive(3, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            sample(3, rdy, rv, rd, er, dbg);
            n_checks++;
            if (rdy !== 1'b0) begin n_errors++; $display("FAIL wait_ready_low N+%0d: got %b want 0", k, rdy); end
            n_checks++;
            if (rv !== (k == 4)) begin n_errors++; $display("FAIL wait_rsp_valid N+%0d: got %b want %b", k, rv, (k == 4)); end
            if (k == 4) begin
                n_checks++;
                if ({er, rd} !== 33'h0) begin n_errors++; $display("FAIL wait_store_rsp: got err=%b rd=%h want 0/0", er, rd); end
            end
        end
        @(negedge clk);
        sample(3, rdy, rv, rd, er, dbg);
        n_checks++;
        if (rdy !== 1'b1 || rv !== 1'b0) begin n_errors++; $display("FAIL wait_ready_N+5: got ready=%b valid=%b want 1/0", rdy, rv); end
        @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b1, SIZE_BYTE, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        n = 1;
        sample(3, rdy, rv, rd, er, dbg);
        n_checks++;
        if (rdy !== 1'b0) begin n_errors++; $display("FAIL held_req_accepted: got ready=%b want 0", rdy); end
        while (!rv && n < 20) begin @(negedge clk); n++; sample(3, rdy, rv, rd, er, dbg); end
        n_checks++;
        if (n != 4) begin n_errors++; $display("FAIL wait_latency: got %0d want 4", n); end
        n_checks++;
        if (rd !== 32'hA5A51234 || er !== 1'b0) begin n_errors++; $display("FAIL wait_load: got %h want a5a51234", rd); end
    endtask

    task automatic test_reset_mid();
        logic rdy, rv, er; logic [31:0] rd; logic [15:0] dbg; int lat; bit to;
        int n;
        bit bad;
        @(negedge clk);
        n = 0;
        sample(3, rdy, rv, rd, er, dbg);
        while (!rdy && n < 20) begin @(negedge clk); n++; sample(3, rdy, rv, rd, er, dbg); end
        drive(3, 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h12345678);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        sample(3, rdy, rv, rd, er, dbg);
        n_checks++;
        if (rdy !== 1'b0 || rv !== 1'b0 || er !== 1'b0 || rd !== 32'h0 || dbg !== 16'h0) begin
            n_errors++; $display("FAIL rst_mid_outputs: got rdy=%b v=%b e=%b rd=%h dbg=%h want all 0", rdy, rv, er, rd, dbg);
        end
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sample(3, rdy, rv, rd, er, dbg);
            if (rv !== 1'b0 || rdy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin n_errors++; $display("FAIL rst_mid_hold: got a pulse or ready during reset, want none"); end
        rst3 = 1'b0;
        xact(3, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'h0 || er !== 1'b0) begin n_errors++; $display("FAIL abandoned_store: got %h want 00000000", rd); end
        xact(3, 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, rd, er, dbg, lat, to);
        n_checks++;
        if (to || rd !== 32'hA5A51234) begin n_errors++; $display("FAIL ram_survives_rst: got %h want a5a51234", rd); end
    endtask

    task automatic test_random(input int which, input int n_ops);
        logic we, u, er, eer;
        logic [1:0] sz;
        logic [31:0] a, d, rd, erd;
        logic [15:0] dbg;
        int lat, r, exp_lat;
        bit to;
        exp_lat = (which == 0) ? 1 : 4;
        for (int i = 0; i < n_ops; i++) begin
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 7));
            sz = (r == 7) ? 2'b11 : 2'(r % 3);
            r  = int'($urandom_range(0, 15));
            if (r < 8)       a = $urandom_range(0, 63);
            else if (r < 15) a = $urandom_range(0, MEM_BYTES - 1);
            else             a = $urandom;
            d = $urandom;
            model_op(which, we, sz, u, a, d, erd, eer);
            xact(which, we, sz, u, a, d, rd, er, dbg, lat, to);
            n_checks++;
            if (to) begin
                n_errors++; $display("FAIL rand%0d_timeout op %0d: no response, want one", which, i);
            end else begin
                n_checks++;
                if (rd !== erd) begin n_errors++; $display("FAIL rand%0d_rdata op %0d we=%b sz=%b u=%b a=%h: got %h want %h", which, i, we, sz, u, a, rd, erd); end
                n_checks++;
                if (er !== eer) begin n_errors++; $display("FAIL rand%0d_err op %0d a=%h sz=%b: got %b want %b", which, i, a, sz, er, eer); end
                n_checks++;
                if (lat != exp_lat) begin n_errors++; $display("FAIL rand%0d_latency op %0d: got %0d want %0d", which, i, lat, exp_lat); end
                n_checks++;
                if (dbg !== erd[15:0]) begin n_errors++; $display("FAIL rand%0d_dbg op %0d: got %h want %h", which, i, dbg, erd[15:0]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem0[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        test_reset();
        test_word();
        test_lanes();
        test_faults();
        test_hold();
        test_wait();
        test_reset_mid();
        test_random(0, 10000);
        test_random(3, 300);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
